shift_pipe: RTL and testbench



---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_stage.sv | 43 ++++
 rtl/shift_pipe.sv | 90 +++++++++
 tb/tb_shift_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings and control payload for the pipelined barrel shifter.
// Data, shift and tag widths are per-instance, so the top folds this control struct into its own payload.
package shift_pkg;

    localparam logic [1:0] OP_LOGIC = 2'b00;
    localparam logic [1:0] OP_ARITH = 2'b01;
    localparam logic [1:0] OP_ROT   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef struct packed {
        logic       dir;
        logic [1:0] op;
    } shift_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditionally shifts by 2**STAGE under the selected mode and direction.
// Purely combinational; the top registers its result.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STAGE = 0
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned AMT = 1 << STAGE;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_fill;

    assign w_shl  = i_data << AMT;
    assign w_shr  = i_data >> AMT;
    assign w_rol  = w_shl | (i_data >> (WIDTH - AMT));
    assign w_ror  = w_shr | (i_data << (WIDTH - AMT));
    // Sign fill for arithmetic right: ones in the vacated top AMT bits.
    assign w_fill = i_data[WIDTH-1] ? ~({WIDTH{1'b1}} >> AMT) : '0;

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_ROT:   o_data = (i_dir == DIR_LEFT) ? w_rol : w_ror;
                OP_ARITH: o_data = (i_dir == DIR_RIGHT) ? (w_shr | w_fill) : w_shl;
                OP_LOGIC,
                OP_RSVD:  o_data = (i_dir == DIR_LEFT) ? w_shl : w_shr;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one register per shift stage, global stall, tag carried in order.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shift,
    input  logic                     in_dir,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shift;
        shift_ctrl_t      ctrl;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t         r_pay [SHW];
    logic [SHW-1:0]   r_valid;

    payload_t         w_src [SHW];
    payload_t         w_nxt [SHW];
    logic [WIDTH-1:0] w_stage_data [SHW];
    logic [SHW-1:0]   w_vsrc;
    logic             w_advance;

    // Whole pipe moves or holds together; bubbles are carried, never squeezed out.
    assign w_advance = !r_valid[SHW-1] || out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_src[k] = '{data: in_data, shift: in_shift,
                                ctrl: '{dir: in_dir, op: in_op}, tag: in_tag};
            assign w_vsrc[k] = in_valid;
        end else begin : g_body
            assign w_src[k]  = r_pay[k-1];
            assign w_vsrc[k] = r_valid[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .i_data (w_src[k].data),
            .i_en   (w_src[k].shift[k]),
            .i_dir  (w_src[k].ctrl.dir),
            .i_op   (w_src[k].ctrl.op),
            .o_data (w_stage_data[k])
        );

        assign w_nxt[k] = '{data: w_stage_data[k], shift: w_src[k].shift,
                            ctrl: w_src[k].ctrl, tag: w_src[k].tag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < SHW; i++) begin
                r_pay[i] <= '0;
            end
        end else if (w_advance) begin
            r_valid <= w_vsrc;
            for (int i = 0; i < SHW; i++) begin
                r_pay[i] <= w_nxt[i];
            end
        end
    end

    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_pay[SHW-1].data;
    assign out_tag   = r_pay[SHW-1].tag;
    assign out_zero  = (r_pay[SHW-1].data == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=16): scoreboard of expected results and acceptance
// times, compared against every output handshake.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shift;
    logic        in_dir;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_zero;

    shift_pipe #(
        .WIDTH (16),
        .TAG_W (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_dir    (in_dir),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stalls = 0;
    logic [15:0] exp_d = '0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] sh,
                                              input logic dir, input logic [1:0] op);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            if (op == OP_ROT) r = dir ? {r[14:0], r[15]} : {r[0], r[15:1]};
            else if (dir) r = {r[14:0], 1'b0};
            else if (op == OP_ARITH) r = {d[15], r[15:1]};
            else r = {1'b0, r[15:1]};
        end
        return r;
    endfunction

    // Monitor: pop on output handshake, push on input handshake, track stall cycles.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("out_unexpected", 32'(out_valid), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_tag", 32'(out_tag), 32'(e.tag));
                    check("out_zero", 32'(out_zero), 32'(e.data == 16'h0));
                    check("latency", 32'(cyc - e.cyc), 32'(LAT + stalls - e.stl));
                end
            end
            if (in_valid && in_ready) sb_q.push_back('{exp_d, in_tag, cyc, stalls});
            if (!in_ready) stalls++;
        end
        cyc++;
    end

    task automatic present(input logic [15:0] d, input logic [3:0] sh, input logic dir,
                           input logic [1:0] op, input logic [3:0] tag, input logic [15:0] exp);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_dir   = dir;
        in_op    = op;
        in_tag   = tag;
        exp_d    = exp;
    endtask

    task automatic wait_accept(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'(1));
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] sh, input logic dir,
                        input logic [1:0] op, input logic [3:0] tag, input logic [15:0] exp);
        present(d, sh, dir, op, tag, exp);
        wait_accept("accept");
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'(1));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] a_exp;
        logic [3:0]  sh;
        logic        dir;
        logic [1:0]  op;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_shift = '0;
        in_dir = 1'b0;
        in_op = '0;
        in_tag = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_tag", 32'(out_tag), 32'(0));
        check("rst_out_zero", 32'(out_zero), 32'(1));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Mode sweep
        send(16'h8000, 4'd3, DIR_RIGHT, OP_LOGIC, 4'h1, 16'h1000);
        send(16'h8000, 4'd3, DIR_RIGHT, OP_ARITH, 4'h2, 16'hF000);
        send(16'h00FF, 4'd15, DIR_LEFT, OP_LOGIC, 4'h3, 16'h8000);
        send(16'h8001, 4'd4, DIR_LEFT, OP_ROT, 4'h4, 16'h0018);
        send(16'h8001, 4'd1, DIR_RIGHT, OP_ROT, 4'h5, 16'hC000);
        idle();
        drain("drain_modes");

        // Edge cases: shift 0 in every mode, reserved op, zero operand
        for (int o = 0; o < 4; o++) begin
            for (int dr = 0; dr < 2; dr++) begin
                send(16'hA5C3, 4'd0, dr[0], o[1:0], 4'(o * 2 + dr), 16'hA5C3);
            end
        end
        send(16'hF0F0, 4'd4, DIR_RIGHT, OP_RSVD, 4'hA, 16'h0F0F);
        send(16'h0000, 4'd7, DIR_LEFT, OP_ROT, 4'hB, 16'h0000);
        idle();
        drain("drain_edges");

        // Back-to-back random stream
        for (int i = 0; i < 20; i++) begin
            d   = 16'($urandom);
            sh  = 4'($urandom_range(0, 15));
            dir = 1'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            send(d, sh, dir, op, 4'(i), ref_shift(d, sh, dir, op));
        end
        idle();
        drain("drain_stream");

        // Back-pressure with a full pipe
        d = 16'h9C31;
        a_exp = ref_shift(d, 4'd5, DIR_RIGHT, OP_ARITH);
        send(d, 4'd5, DIR_RIGHT, OP_ARITH, 4'h1, a_exp);
        for (int i = 2; i <= 4; i++) begin
            d = 16'($urandom);
            send(d, 4'(i), DIR_LEFT, OP_ROT, 4'(i), ref_shift(d, 4'(i), DIR_LEFT, OP_ROT));
        end
        d = 16'h1234;
        present(d, 4'd2, DIR_LEFT, OP_LOGIC, 4'h5, ref_shift(d, 4'd2, DIR_LEFT, OP_LOGIC));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_out_data", 32'(out_data), 32'(a_exp));
            check("bp_out_tag", 32'(out_tag), 32'(4'h1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("bp_accept");
        idle();
        drain("drain_bp");

        // Reset with three operations in flight
        send(16'h1111, 4'd1, DIR_LEFT, OP_LOGIC, 4'h6, 16'h2222);
        send(16'h2222, 4'd1, DIR_LEFT, OP_LOGIC, 4'h7, 16'h4444);
        send(16'h4444, 4'd1, DIR_LEFT, OP_LOGIC, 4'h8, 16'h8888);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_out_data", 32'(out_data), 32'(0));
        check("mid_rst_out_zero", 32'(out_zero), 32'(1));
        check("mid_rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h00F0;
        in_shift = 4'd4;
        in_dir = DIR_RIGHT;
        in_op = OP_LOGIC;
        in_tag = 4'h9;
        exp_d = 16'h000F;
        wait_accept("post_rst_accept");
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(out_valid), 32'(0));
        end
        drain("drain_post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
